// File: rtl/int32_accum.sv
// Streaming signed 32-bit reduction stage: sums up to MAX_LEN elements per vector and
// presents sum, count and sticky overflow. Define INT32_ACCUM_SAT_EN for saturating sums.
module int32_accum #(
  parameter int unsigned MAX_LEN = 256,
  localparam int unsigned CW     = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [31:0]   in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [CW-1:0] out_count,
  output logic          out_ovf
);

  localparam logic [CW-1:0] MaxLenC = CW'(MAX_LEN);

  typedef enum logic [0:0] {StAcc, StDone} state_e;

  state_e        r_state, w_state_d;
  logic [31:0]   r_acc;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic          w_accept;
  logic          w_take;
  logic          w_term;
  logic [31:0]   w_sum;
  logic [31:0]   w_acc_d;
  logic [CW-1:0] w_count_inc;
  logic          w_add_ovf;

  assign w_accept    = in_valid & (r_state == StAcc);
  assign w_take      = out_ready & (r_state == StDone);
  assign w_count_inc = r_count + 1'b1;
  assign w_term      = in_last | (w_count_inc == MaxLenC);

  assign w_sum     = r_acc + in_data;
  // Overflow: operands agree in sign but the result does not.
  assign w_add_ovf = (r_acc[31] == in_data[31]) & (w_sum[31] != r_acc[31]);

`ifdef INT32_ACCUM_SAT_EN
  always_comb begin
    w_acc_d = w_sum;
    if (w_add_ovf) begin
      w_acc_d = r_acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end
`else
  assign w_acc_d = w_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StAcc;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StAcc:   if (w_accept && w_term) w_state_d = StDone;
      StDone:  if (out_ready) w_state_d = StAcc;
      default: w_state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_take) begin
      r_acc   <= 32'd0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= w_acc_d;
      r_count <= w_count_inc;
      r_ovf   <= r_ovf | w_add_ovf;
    end
  end

  assign in_ready  = (r_state == StAcc);
  assign out_valid = (r_state == StDone);
  assign out_data  = r_acc;
  assign out_count = r_count;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_int32_accum.sv
// Directed self-checking bench for int32_accum built with MAX_LEN=4.
module tb_int32_accum;

  localparam int unsigned MaxLen = 4;
  localparam int unsigned Cw     = $clog2(MaxLen + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_last;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [Cw-1:0] out_count;
  logic          out_ovf;

  int total = 0;
  int bad   = 0;

  int32_accum #(.MAX_LEN(MaxLen)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_basic();
    send(32'd3, 1'b0);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
    send(-32'sd5, 1'b0);
    send(32'd10, 1'b1);
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    total++;
    if (out_data !== 32'd8) begin bad++; $display("FAIL basic_data got=%0d exp=8", $signed(out_data)); end
    total++;
    if (out_count !== 3'd3) begin bad++; $display("FAIL basic_count got=%0d exp=3", out_count); end
    total++;
    if (out_ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b exp=0", out_ovf); end
    tick();
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready_held got=%b exp=0", in_ready); end
    take();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_release got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_maxlen();
    in_valid = 1'b1;
    in_data  = 32'd1;
    in_last  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'd4 || out_count !== 3'd4) begin
      bad++;
      $display("FAIL maxlen_result got v=%b d=%0d c=%0d exp 1/4/4", out_valid, out_data, out_count);
    end
    tick();  // fifth element presented but must not be accepted
    total++;
    if (out_count !== 3'd4 || out_data !== 32'd4) begin
      bad++;
      $display("FAIL maxlen_fifth_held got d=%0d c=%0d exp 4/4", out_data, out_count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_last   = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'd1 || out_count !== 3'd1) begin
      bad++;
      $display("FAIL maxlen_newvec got v=%b d=%0d c=%0d exp 1/1/1", out_valid, out_data, out_count);
    end
    take();
  endtask

  task automatic test_overflow();
    logic [31:0] exp_d;
`ifdef INT32_ACCUM_SAT_EN
    exp_d = 32'h7FFF_FFFF;
`else
    exp_d = 32'h8000_0000;
`endif
    send(32'h7FFF_FFFF, 1'b0);
    send(32'd1, 1'b1);
    total++;
    if (out_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", out_ovf); end
    total++;
    if (out_data !== exp_d) begin bad++; $display("FAIL ovf_data got=%h exp=%h", out_data, exp_d); end
    take();
    send(32'd2, 1'b1);
    total++;
    if (out_data !== 32'd2 || out_ovf !== 1'b0 || out_count !== 3'd1) begin
      bad++;
      $display("FAIL ovf_clear got d=%0d o=%b c=%0d exp 2/0/1", out_data, out_ovf, out_count);
    end
    take();
  endtask

  task automatic test_backpressure();
    send(32'd5, 1'b0);
    send(32'd6, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'd99;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'd11 || out_count !== 3'd2) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got v=%b r=%b d=%0d c=%0d exp 1/0/11/2",
                 i, out_valid, in_ready, out_data, out_count);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_release got r=%b v=%b exp 1/0", in_ready, out_valid);
    end
    send(32'd3, 1'b1);
    total++;
    if (out_data !== 32'd3 || out_count !== 3'd1) begin
      bad++;
      $display("FAIL bp_nothing_accepted got d=%0d c=%0d exp 3/1", out_data, out_count);
    end
    take();
  endtask

  task automatic test_reset_mid();
    send(32'd7, 1'b0);
    send(32'd9, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_state got v=%b r=%b exp 0/1", out_valid, in_ready);
    end
    send(32'd4, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'd4 || out_count !== 3'd1) begin
      bad++;
      $display("FAIL rstmid_result got v=%b d=%0d c=%0d exp 1/4/1", out_valid, out_data, out_count);
    end
    take();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    in_data   = -32'sd100;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== -32'sd100 || out_count !== 3'd1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first got v=%b d=%0d c=%0d r=%b exp 1/-100/1/0",
               out_valid, $signed(out_data), out_count, in_ready);
    end
    in_data = 32'd50;
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_bubble got v=%b r=%b exp 0/1", out_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'd50 || out_count !== 3'd1) begin
      bad++;
      $display("FAIL b2b_second got v=%b d=%0d c=%0d exp 1/50/1", out_valid, out_data, out_count);
    end
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_idle got v=%b r=%b exp 0/1", out_valid, in_ready);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_maxlen();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
